temporal_spike_encoder: RTL and testbench
=========================================

# temporal_spike_encoder

Clocked front-end stage that converts a vector of integer spike times into race-logic spike pulses for the downstream winner-take-all array. It accepts one sample per gamma cycle over a valid/ready handshake and holds the WTA in reset between cycles. It then replays each channel's value as a pulse of `PULSE_WIDTH` cycles starting at gamma-relative time `value`. All outputs toward the WTA come straight from flops, so the asynchronous race logic never sees glitches.

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: number of clock cycles in one gamma window (≥2).
- `PULSE_WIDTH`, 8: spike pulse length in cycles (1..`GAMMA_CYCLE_WIDTH`).
- `NUM_INPUTS`, 16: channel count; matches the WTA width.
- `VALUE_WIDTH`, `$clog2(GAMMA_CYCLE_WIDTH)`: bits per channel spike time (derived; do not override).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample available.
- `in_ready`  out  1  encoder can accept a sample.
- `in_values`  in  `NUM_INPUTS*VALUE_WIDTH`  channel i at bits `[i*VALUE_WIDTH +: VALUE_WIDTH]`.
- `in_en`  in  `NUM_INPUTS`  per-channel enable; 0 means the channel never spikes this cycle.
- `output_spikes`  out  `NUM_INPUTS`  spike lines to the WTA `input_spikes`.
- `wta_rst`  out  1  drives the WTA `rst`.
- `gamma_time`  out  `VALUE_WIDTH`  current gamma-relative time; 0 outside RUN.
- `gamma_done`  out  1  one-cycle pulse on the last RUN cycle.

## Operation
- FSM states: IDLE, CLEAR, RUN.
- **IDLE**
  - `in_ready`=1, `wta_rst`=1, `output_spikes`=0.
  - On `in_valid && in_ready`, capture `in_values` and `in_en` into internal registers, then go to CLEAR.
- **CLEAR**
  - Lasts exactly one cycle.
  - `in_ready`=0, `wta_rst`=1, `output_spikes`=0, counter loaded to 0.
  - Then go to RUN.
- **RUN**
  - `wta_rst`=0, `in_ready`=0, counter t counts 0..`GAMMA_CYCLE_WIDTH`-1, and `gamma_time`=t.
  - `output_spikes[i]` = `en[i] && t ≥ v[i] && t < v[i]+PULSE_WIDTH`. Evaluate the sum at `VALUE_WIDTH+1` bits so it cannot wrap.
  - A pulse that would extend past the window is truncated at t=`GAMMA_CYCLE_WIDTH`-1. It never wraps into the next cycle.
  - At t=`GAMMA_CYCLE_WIDTH`-1: `gamma_done`=1, and the next state is IDLE.
- Captured values are stable for the whole RUN. Input changes after the handshake have no effect.
- Channels with equal values spike in the same cycle. Arbitration between them is the WTA's job.
- `in_values` entries ≥ `GAMMA_CYCLE_WIDTH`, possible only when the window is not a power of two, never spike.

## Timing
- Reset values: state IDLE, `in_ready`=1, `wta_rst`=1, `output_spikes`=0, `gamma_time`=0, `gamma_done`=0, captured registers 0.
- Handshake at edge N. CLEAR is visible in cycle N+1, RUN t=0 in cycle N+2, and the last RUN cycle is N+1+`GAMMA_CYCLE_WIDTH`.
- Throughput: one sample per `GAMMA_CYCLE_WIDTH`+2 cycles, including the IDLE cycle in which `in_ready` is re-asserted.
- `in_ready` is registered. It does not depend combinationally on `in_valid`.
- All outputs are flop outputs, with no combinational path from any input.
- `rst` asserted mid-RUN immediately forces all outputs to their reset values. The in-flight sample is discarded, and no `gamma_done` pulse is produced.

## Structure
- Shared package `tnn_pkg`:
  - `enc_state_t` enum (IDLE/CLEAR/RUN).
  - Helper function for the pulse-window compare.
  - `GAMMA_CYCLE_WIDTH` and `PULSE_WIDTH` defaults, which the WTA stages share.
- Sub-module `spike_pulse_gen`:
  - One instance per channel, generated.
  - Inputs: captured value, enable, t, run flag.
  - Contains the per-channel output flop.
- Top level holds the FSM, counter and capture registers. Target size is about 150–250 lines of RTL.

## Test plan
- **Reset, then idle:** expect `in_ready`=1, `wta_rst`=1, all spikes 0. Assert `rst` mid-RUN and check that all outputs return to reset values asynchronously, with no `gamma_done`.
- **Single channel, defaults:** ch0=3, other channels disabled. `output_spikes[0]` is high for t=3..10 (8 cycles), and `gamma_done` pulses at t=15.
- **Truncation:** ch2=12. The spike is high for t=12..15 only, with none after the cycle returns to IDLE.
- **Ties and ordering:** ch1=5, ch4=5, ch7=2. ch7 rises at t=2, and ch1 and ch4 rise together at t=5.
  - With the WTA attached, only ch7 propagates.
- **Back-to-back samples:** `in_valid` held high with two samples. The second handshake occurs at N+`GAMMA_CYCLE_WIDTH`+2 and the first sample's values are unaffected. `in_en`=0 channels stay silent throughout.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared types and defaults for the temporal neural network pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tnn_pkg;

    // Window defaults shared by the encoder and the WTA stages.
    localparam int TNN_GAMMA_CYCLE_WIDTH = 16;
    localparam int TNN_PULSE_WIDTH       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } enc_state_t;

    // True when time t lies inside [value, value+width). The end point is
    // formed one bit wider than the operands so a late value plus a long
    // pulse cannot wrap round and close the window early.
    function automatic logic in_pulse_window(input logic [31:0] value,
                                             input logic [31:0] t,
                                             input logic [31:0] width);
        logic [32:0] end_t;
        end_t = {1'b0, value} + {1'b0, width};
        return (t >= value) && ({1'b0, t} < end_t);
    endfunction

endpackage

// File: rtl/spike_pulse_gen.sv
// Per-channel race-logic pulse generator with a registered spike output.
// Latency: 1 cycle; the spike flop is fed with next-cycle time and run flag.
// Backpressure: none; free-running, driven by the encoder FSM.
//
// Ports:
//   clk, rst  : clock, async active-high reset
//   value_i   : captured spike time for this channel
//   en_i      : captured channel enable
//   t_i       : gamma time that will be current in the next cycle
//   run_i     : next cycle is a RUN cycle
//   spike_o   : glitch-free spike line towards the WTA
module spike_pulse_gen
    import tnn_pkg::*;
#(
    parameter int VALUE_WIDTH = 4,
    parameter int PULSE_WIDTH = TNN_PULSE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VALUE_WIDTH-1:0] value_i,
    input  logic                   en_i,
    input  logic [VALUE_WIDTH-1:0] t_i,
    input  logic                   run_i,
    output logic                   spike_o
);

    logic spike_q;
    logic spike_d;

    always_comb begin
        spike_d = run_i && en_i &&
                  in_pulse_window(32'(value_i), 32'(t_i), 32'(PULSE_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;

endmodule

// File: rtl/temporal_spike_encoder.sv
// Converts a vector of integer spike times into race-logic pulses per gamma window.
// Latency: handshake at edge N -> CLEAR in N+1, RUN t=0 in N+2, done in N+1+GAMMA.
// Backpressure: in_ready low from CLEAR through the last RUN cycle; one sample per GAMMA+2 cycles.
//
// Ports:
//   clk, rst       : clock, async active-high reset
//   in_valid/ready : sample handshake; in_ready is a flop output
//   in_values      : channel i spike time at [i*VALUE_WIDTH +: VALUE_WIDTH]
//   in_en          : per-channel enable, 0 = channel silent this window
//   output_spikes  : spike lines to the WTA
//   wta_rst        : holds the WTA in reset outside RUN
//   gamma_time     : gamma-relative time, 0 outside RUN
//   gamma_done     : one-cycle pulse on the last RUN cycle
module temporal_spike_encoder
    import tnn_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = TNN_GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH       = TNN_PULSE_WIDTH,
    parameter int NUM_INPUTS        = 16,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] in_values,
    input  logic [NUM_INPUTS-1:0]             in_en,
    output logic [NUM_INPUTS-1:0]             output_spikes,
    output logic                              wta_rst,
    output logic [VALUE_WIDTH-1:0]            gamma_time,
    output logic                              gamma_done
);

    localparam logic [VALUE_WIDTH-1:0] T_LAST = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    enc_state_t                        state_q, state_d;
    logic [VALUE_WIDTH-1:0]            t_q, t_d;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] vals_q;
    logic [NUM_INPUTS-1:0]             en_q;
    logic                              capture;
    logic                              run_d;

    logic                              in_ready_q;
    logic                              wta_rst_q;
    logic [VALUE_WIDTH-1:0]            gamma_time_q;
    logic                              gamma_done_q;

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    capture = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RUN;
                t_d     = '0;
            end
            RUN: begin
                if (t_q == T_LAST) begin
                    state_d = IDLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + VALUE_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
        run_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            vals_q  <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            if (capture) begin
                vals_q <= in_values;
                en_q   <= in_en;
            end
        end
    end

    // Every output is registered from the next-state view, so what the WTA
    // sees in a cycle is a clean flop value matching that cycle's state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q   <= 1'b1;
            wta_rst_q    <= 1'b1;
            gamma_time_q <= '0;
            gamma_done_q <= 1'b0;
        end else begin
            in_ready_q   <= (state_d == IDLE);
            wta_rst_q    <= !run_d;
            gamma_time_q <= run_d ? t_d : '0;
            gamma_done_q <= run_d && (t_d == T_LAST);
        end
    end

    // The pulse generators read vals_q/en_q already during CLEAR, which is
    // why capture happens one cycle before t=0 is needed.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        spike_pulse_gen #(
            .VALUE_WIDTH (VALUE_WIDTH),
            .PULSE_WIDTH (PULSE_WIDTH)
        ) u_pulse (
            .clk     (clk),
            .rst     (rst),
            .value_i (vals_q[i*VALUE_WIDTH +: VALUE_WIDTH]),
            .en_i    (en_q[i]),
            .t_i     (t_d),
            .run_i   (run_d),
            .spike_o (output_spikes[i])
        );
    end

    assign in_ready   = in_ready_q;
    assign wta_rst    = wta_rst_q;
    assign gamma_time = gamma_time_q;
    assign gamma_done = gamma_done_q;

endmodule

// File: tb/tb_temporal_spike_encoder.sv
// Directed bench for temporal_spike_encoder with hand-computed pulse windows.
// Latency: checks CLEAR at N+1, RUN t=0 at N+2, done at N+1+16.
// Backpressure: exercises held in_valid across two back-to-back windows.
module tb_temporal_spike_encoder;

    localparam int GCW = 16;
    localparam int PW  = 8;
    localparam int NI  = 16;
    localparam int VW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NI*VW-1:0] in_values;
    logic [NI-1:0]   in_en;
    logic [NI-1:0]   output_spikes;
    logic            wta_rst;
    logic [VW-1:0]   gamma_time;
    logic            gamma_done;

    int errors = 0;
    int checks = 0;
    logic [NI-1:0] hist [GCW];

    always #5 clk = ~clk;

    temporal_spike_encoder #(
        .GAMMA_CYCLE_WIDTH (GCW),
        .PULSE_WIDTH       (PW),
        .NUM_INPUTS        (NI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_values     (in_values),
        .in_en         (in_en),
        .output_spikes (output_spikes),
        .wta_rst       (wta_rst),
        .gamma_time    (gamma_time),
        .gamma_done    (gamma_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_hi(input int ch);
        for (int t = 0; t < GCW; t++) if (hist[t][ch]) return t;
        return -1;
    endfunction

    function automatic int hi_count(input int ch);
        int n = 0;
        for (int t = 0; t < GCW; t++) if (hist[t][ch]) n++;
        return n;
    endfunction

    // Present a sample from a negedge and return #1 after the handshake edge.
    task automatic send(input logic [NI*VW-1:0] vals, input logic [NI-1:0] en);
        int n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_values = vals;
        in_en     = en;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Walk CLEAR, the 16 RUN cycles and the following IDLE cycle.
    task automatic check_run(input logic [NI*VW-1:0] vals, input logic [NI-1:0] en);
        logic [NI-1:0] exp;
        int v;
        @(negedge clk);
        check("clr_ready", 32'(in_ready), 32'd0);
        check("clr_wrst",  32'(wta_rst), 32'd1);
        check("clr_spk",   32'(output_spikes), 32'd0);
        check("clr_time",  32'(gamma_time), 32'd0);
        for (int t = 0; t < GCW; t++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                v = int'(vals[i*VW +: VW]);
                exp[i] = en[i] && (t >= v) && (t < v + PW);
            end
            check("run_time",  32'(gamma_time), 32'(t));
            check("run_wrst",  32'(wta_rst), 32'd0);
            check("run_ready", 32'(in_ready), 32'd0);
            check("run_spk",   32'(output_spikes), 32'(exp));
            check("run_done",  32'(gamma_done), 32'(t == GCW - 1));
            hist[t] = output_spikes;
        end
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_wrst",  32'(wta_rst), 32'd1);
        check("idle_spk",   32'(output_spikes), 32'd0);
        check("idle_time",  32'(gamma_time), 32'd0);
        check("idle_done",  32'(gamma_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_values = '0;
        in_en     = '0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_wrst",  32'(wta_rst), 32'd1);
        check("rst_spk",   32'(output_spikes), 32'd0);
        check("rst_time",  32'(gamma_time), 32'd0);
        check("rst_done",  32'(gamma_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle0_ready", 32'(in_ready), 32'd1);
        check("idle0_wrst",  32'(wta_rst), 32'd1);
        check("idle0_spk",   32'(output_spikes), 32'd0);

        // Single channel: ch0=3 -> high t=3..10, inputs scrambled after handshake.
        send(64'h3, 16'h0001);
        in_valid = 1'b0; in_values = '1; in_en = '1;
        check_run(64'h3, 16'h0001);
        check("ch0_first", 32'(first_hi(0)), 32'd3);
        check("ch0_len",   32'(hi_count(0)), 32'd8);

        // Truncation: ch2=12 -> high t=12..15 only.
        send(64'hC00, 16'h0004);
        in_valid = 1'b0; in_values = '1; in_en = '1;
        check_run(64'hC00, 16'h0004);
        check("ch2_first", 32'(first_hi(2)), 32'd12);
        check("ch2_len",   32'(hi_count(2)), 32'd4);
        @(negedge clk);
        check("trunc_after", 32'(output_spikes), 32'd0);

        // Ties: ch1=5, ch4=5, ch7=2.
        send(64'h2005_0050, 16'h0092);
        in_valid = 1'b0; in_values = '0; in_en = '1;
        check_run(64'h2005_0050, 16'h0092);
        check("ch7_first", 32'(first_hi(7)), 32'd2);
        check("ch1_first", 32'(first_hi(1)), 32'd5);
        check("ch4_first", 32'(first_hi(4)), 32'd5);

        // Back-to-back with in_valid held: B1 then B2.
        send(64'h0000_0090_0010_0000, 16'h0208);
        in_values = 64'h0000_0000_00E0_F000;
        in_en     = 16'h0028;
        check_run(64'h0000_0090_0010_0000, 16'h0208);
        check("b1_ch3_first", 32'(first_hi(3)), 32'd0);
        check("b1_ch3_len",   32'(hi_count(3)), 32'd8);
        check("b1_ch9_first", 32'(first_hi(9)), 32'd9);
        check("b1_ch9_len",   32'(hi_count(9)), 32'd7);
        check("b1_ch5_len",   32'(hi_count(5)), 32'd0);
        // Still in the IDLE cycle with in_valid high: the next edge is handshake 2.
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_values = '1; in_en = '1;
        check_run(64'h0000_0000_00E0_F000, 16'h0028);
        check("b2_ch5_first", 32'(first_hi(5)), 32'd14);
        check("b2_ch5_len",   32'(hi_count(5)), 32'd2);
        check("b2_ch3_first", 32'(first_hi(3)), 32'd15);
        check("b2_ch6_len",   32'(hi_count(6)), 32'd0);

        // Reset mid-RUN: outputs return immediately, no gamma_done.
        send(64'h3, 16'h0001);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("prerst_time", 32'(gamma_time), 32'd5);
        check("prerst_spk",  32'(output_spikes), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_wrst",  32'(wta_rst), 32'd1);
        check("mrst_spk",   32'(output_spikes), 32'd0);
        check("mrst_time",  32'(gamma_time), 32'd0);
        check("mrst_done",  32'(gamma_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < GCW + 2; k++) begin
            @(negedge clk);
            check("postrst_done", 32'(gamma_done), 32'd0);
        end
        check("postrst_ready", 32'(in_ready), 32'd1);
        check("postrst_spk",   32'(output_spikes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
